seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 168 ++++++++++++++++
 tb/tb_seq_alu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu -- sequential 32-bit ALU with a bit-serial shifter.
//
// Non-shift operations are computed in the accept cycle and are presented one
// cycle later. Shifts (SLL/SRL/SRA) move one bit position per cycle in SHIFT,
// driven by a 5-bit down-counter loaded from op_b[4:0]. The result is held in
// DONE until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operation presented on alu_ctrl/op_a/op_b
//   in_ready   unit can accept an operation (IDLE only)
//   alu_ctrl   4-bit operation code (ALU_* encodings below)
//   op_a       first operand / shift source
//   op_b       second operand / op_b[4:0] shift amount
//   flush      abort any in-flight operation
//   out_valid  result/zero valid (DONE only)
//   out_ready  consumer accepts result
//   result     registered operation result
//   zero       registered flag, result == 0
//   busy       high in SHIFT or DONE
module seq_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        busy
);

  // Operation encodings: {funct7[5], funct3} of the RV32I ALU instructions.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;       // remaining shift steps
  logic [31:0] sh_val;    // partially shifted operand
  logic [3:0]  sh_ctrl;   // latched shift opcode

  logic [31:0] acc_res;   // single-cycle result for the operation being accepted
  logic [31:0] step_res;  // sh_val moved by one bit position
  logic        is_shift;

  function automatic logic shift_op(input logic [3:0] c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

  // Shift opcodes return op_a here: this value is only used for shift-by-0,
  // real shifts go through the SHIFT state, so no barrel shifter is built.
  function automatic logic [31:0] alu_comb(input logic [3:0] c,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (c)
      ALU_SUB:  r = a - b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  r = a ^ b;
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  r = a;
      default:  r = a + b;   // ADD and any unrecognised code
    endcase
    return r;
  endfunction

  function automatic logic [31:0] shift_step(input logic [3:0] c,
                                             input logic [31:0] v);
    logic [31:0] r;
    case (c)
      ALU_SLL: r = {v[30:0], 1'b0};
      ALU_SRA: r = {v[31], v[31:1]};
      default: r = {1'b0, v[31:1]};  // SRL
    endcase
    return r;
  endfunction

  assign is_shift = shift_op(alu_ctrl);
  assign acc_res  = alu_comb(alu_ctrl, op_a, op_b);
  assign step_res = shift_step(sh_ctrl, sh_val);

  // result and zero are always written from the same value in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      sh_val    <= 32'd0;
      sh_ctrl   <= ALU_ADD;
      result    <= 32'd0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      // Beats accept and handoff; the operation is dropped, result keeps its value.
      state     <= IDLE;
      cnt       <= 5'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            busy     <= 1'b1;
            in_ready <= 1'b0;
            if (is_shift && (op_b[4:0] != 5'd0)) begin
              state   <= SHIFT;
              cnt     <= op_b[4:0];
              sh_val  <= op_a;
              sh_ctrl <= alu_ctrl;
            end else begin
              state     <= DONE;
              result    <= acc_res;
              zero      <= (acc_res == 32'd0);
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          sh_val <= step_res;
          cnt    <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state     <= DONE;
            result    <= step_res;
            zero      <= (step_res == 32'd0);
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Handoff cycle never accepts; in_ready rises only after it.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_seq_alu;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b;
  logic        in_ready, out_valid, zero, busy;
  logic [31:0] result;

  int pass_cnt = 0;
  int total    = 0;

  seq_alu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: what the operation means arithmetically.
  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    int sh;
    sa = a;
    sh = int'(b % 32);
    case (c)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << sh;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return sa >>> sh;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  // Cycles from the accept edge to the first sample with out_valid high.
  function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
    if (c == ALU_SLL || c == ALU_SRL || c == ALU_SRA) return int'(b % 32) + 1;
    return 1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one op from IDLE, scrambles inputs while busy, waits (bounded) for
  // out_valid, captures result/zero, then hands off.
  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic z);
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    res = result; z = zero;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    alu_ctrl = '0; op_a = '0; op_b = '0;
    tick(); tick();
    total++;
    if ({result, zero, out_valid, busy, in_ready} !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset: res=%h z=%b ov=%b busy=%b ir=%b, want 0 1 0 0 1",
               result, zero, out_valid, busy, in_ready);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed;
    logic [3:0]  c [7] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SRA, ALU_SRL, ALU_SLL};
    logic [31:0] a [7] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                           32'h80000000, 32'h80000000, 32'hDEADBEEF};
    logic [31:0] b [7] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd31, 32'd31, 32'hFFFFFFE0};
    logic [31:0] er[7] = '{32'h80000000, 32'd0, 32'd1, 32'd0,
                           32'hFFFFFFFF, 32'd1, 32'hDEADBEEF};
    int          el[7] = '{1, 1, 1, 1, 32, 32, 1};
    int lat; logic [31:0] res; logic z;
    for (int i = 0; i < 7; i++) begin
      do_op(c[i], a[i], b[i], lat, res, z);
      total++;
      if (res !== er[i] || z !== (er[i] == 0) || lat != el[i])
        $display("FAIL directed[%0d]: res=%h z=%b lat=%0d, want res=%h z=%b lat=%0d",
                 i, res, z, lat, er[i], er[i] == 0, el[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] res, exp_r; logic z;
    logic [3:0] c; logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;   // exercise zero results
      exp_r = model(c, a, b);
      do_op(c, a, b, lat, res, z);
      total++;
      if (res !== exp_r || z !== (exp_r == 0) || lat != model_lat(c, b))
        $display("FAIL random[%0d] c=%h a=%h b=%h: res=%h z=%b lat=%0d, want %h %b %0d",
                 i, c, a, b, res, z, lat, exp_r, exp_r == 0, model_lat(c, b));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_r;
    in_valid = 1'b1; alu_ctrl = ALU_XOR; op_a = 32'h1234_5678; op_b = 32'h0F0F_0F0F;
    out_ready = 1'b0;
    exp_r = model(ALU_XOR, 32'h1234_5678, 32'h0F0F_0F0F);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (out_valid !== 1'b1 || result !== exp_r || in_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL hold[%0d]: ov=%b res=%h ir=%b busy=%b, want 1 %h 0 1",
                 k, out_valid, result, in_ready, busy, exp_r);
      else pass_cnt++;
      if (k < 5) tick();
    end
    // Handoff with a new op already waiting: it must not be taken this edge.
    out_ready = 1'b1; in_valid = 1'b1; alu_ctrl = ALU_AND;
    op_a = 32'hFF00_FF00; op_b = 32'h0FF0_0FF0;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL handoff: ov=%b ir=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 32'h0F00_0F00)
      $display("FAIL next_accept: ov=%b res=%h, want 1 0f000f00", out_valid, result);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush;
    int seen; int lat; logic [31:0] res; logic z;
    in_valid = 1'b1; alu_ctrl = ALU_SLL; op_a = 32'h1; op_b = 32'd20; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL flush_shift: ov=%b ir=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    else pass_cnt++;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      if (out_valid) seen++;
      tick();
    end
    total++;
    if (seen != 0) $display("FAIL flush_stale: out_valid cycles=%0d, want 0", seen);
    else pass_cnt++;
    // Flush in IDLE blocks an accept.
    flush = 1'b1; in_valid = 1'b1; alu_ctrl = ALU_ADD; op_a = 32'd3; op_b = 32'd4;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_idle: busy=%b ov=%b ir=%b, want 0 0 1", busy, out_valid, in_ready);
    else pass_cnt++;
    do_op(ALU_OR, 32'hA0, 32'h0B, lat, res, z);
    total++;
    if (res !== 32'hAB || lat != 1)
      $display("FAIL after_flush: res=%h lat=%0d, want 000000ab 1", res, lat);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_shift;
    int seen;
    in_valid = 1'b1; alu_ctrl = ALU_SRA; op_a = 32'h8000_00F0; op_b = 32'd31; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    total++;
    if ({result, zero, out_valid, busy, in_ready} !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_mid: res=%h z=%b ov=%b busy=%b ir=%b, want 0 1 0 0 1",
               result, zero, out_valid, busy, in_ready);
    else pass_cnt++;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid || busy) seen++;
      tick();
    end
    total++;
    if (seen != 0) $display("FAIL reset_stale: active cycles=%0d, want 0", seen);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
